// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared constants for the ID/EX ALU issue path: the 5-bit ALU operation
//   codes, MIPS primary opcodes and R-type funct values, and the packed
//   record that travels through the output and skid registers.
//   The ALU side imports the same package, so both ends agree on the codes.
//   No ports (package).

package alu_issue_pkg;

   // ALU operation codes
   localparam logic [4:0] ALU_AND   = 5'b00000;
   localparam logic [4:0] ALU_OR    = 5'b00001;
   localparam logic [4:0] ALU_ADD   = 5'b00010;
   localparam logic [4:0] ALU_SLL   = 5'b00011;
   localparam logic [4:0] ALU_SRL   = 5'b00100;
   localparam logic [4:0] ALU_SRA   = 5'b00101;
   localparam logic [4:0] ALU_SUB   = 5'b00110;
   localparam logic [4:0] ALU_SLT   = 5'b00111;
   localparam logic [4:0] ALU_NOR   = 5'b01000;
   localparam logic [4:0] ALU_XOR   = 5'b01001;
   localparam logic [4:0] ALU_ADDU  = 5'b01010;
   localparam logic [4:0] ALU_SLTU  = 5'b01011;
   localparam logic [4:0] ALU_SLLV  = 5'b01100;
   localparam logic [4:0] ALU_SRLV  = 5'b01101;
   localparam logic [4:0] ALU_SUBU  = 5'b01110;
   localparam logic [4:0] ALU_SRAV  = 5'b01111;
   localparam logic [4:0] ALU_ADDIU = 5'b10000;
   localparam logic [4:0] ALU_XORI  = 5'b10001;
   localparam logic [4:0] ALU_LUI   = 5'b10010;
   localparam logic [4:0] ALU_SLTI  = 5'b10011;
   localparam logic [4:0] ALU_SLTIU = 5'b10100;

   // MIPS primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type funct values
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // One issued ALU entry (operand width is fixed at 32)
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  oper;
      logic [4:0]  dst;
      logic        wr_en;
      logic        illegal;
   } issue_t;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode
//   Combinational decode of a MIPS instruction into ALU operands, operation
//   code and register-file write target.
//   Ports:
//     instr    in  32  instruction word
//     rs, rt   in  32  forwarded register values
//     alu_a    out 32  operand A (shamt for immediate shifts, else rs)
//     alu_b    out 32  operand B (rt, or extended imm16 for I-type)
//     alu_oper out 5   ALU operation code
//     wr_dst   out 5   destination register (rd for R-type, rt for I-type)
//     wr_en    out 1   entry writes the register file
//     illegal  out 1   unsupported opcode/funct; all other outputs zero

module alu_issue_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_oper,
   output logic [4:0]  wr_dst,
   output logic        wr_en,
   output logic        illegal
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt_num;
   logic [4:0]  rd_num;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign op       = instr[31:26];
   assign rt_num   = instr[20:16];
   assign rd_num   = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_oper = '0;
      wr_dst   = '0;
      wr_en    = 1'b0;
      illegal  = 1'b0;

      if (op == OPC_RTYPE) begin
         case (funct)
            FN_ADD:  alu_oper = ALU_ADD;
            FN_ADDU: alu_oper = ALU_ADDU;
            FN_SUB:  alu_oper = ALU_SUB;
            FN_SUBU: alu_oper = ALU_SUBU;
            FN_AND:  alu_oper = ALU_AND;
            FN_OR:   alu_oper = ALU_OR;
            FN_XOR:  alu_oper = ALU_XOR;
            FN_NOR:  alu_oper = ALU_NOR;
            FN_SLT:  alu_oper = ALU_SLT;
            FN_SLTU: alu_oper = ALU_SLTU;
            FN_SLL:  alu_oper = ALU_SLL;
            FN_SRL:  alu_oper = ALU_SRL;
            FN_SRA:  alu_oper = ALU_SRA;
            FN_SLLV: alu_oper = ALU_SLLV;
            FN_SRLV: alu_oper = ALU_SRLV;
            FN_SRAV: alu_oper = ALU_SRAV;
            default: illegal  = 1'b1;
         endcase
         if (!illegal) begin
            // Immediate shifts take the shift amount on A; variable shifts use rs
            alu_a  = (funct inside {FN_SLL, FN_SRL, FN_SRA}) ? {27'd0, shamt} : rs;
            alu_b  = rt;
            wr_dst = rd_num;
            wr_en  = (rd_num != 5'd0);
         end
      end else begin
         case (op)
            OPC_ADDI:  alu_oper = ALU_ADD;
            OPC_ADDIU: alu_oper = ALU_ADDIU;
            OPC_SLTI:  alu_oper = ALU_SLTI;
            OPC_SLTIU: alu_oper = ALU_SLTIU;
            OPC_ANDI:  alu_oper = ALU_AND;
            OPC_ORI:   alu_oper = ALU_OR;
            OPC_XORI:  alu_oper = ALU_XORI;
            OPC_LUI:   alu_oper = ALU_LUI;
            OPC_LW:    alu_oper = ALU_ADDU;
            OPC_SW:    alu_oper = ALU_ADDU;
            OPC_BEQ:   alu_oper = ALU_SUB;
            OPC_BNE:   alu_oper = ALU_SUB;
            default:   illegal  = 1'b1;
         endcase
         if (!illegal) begin
            alu_a = rs;
            // Logical immediates and lui are zero-extended; sltiu still sign-extends
            if (op inside {OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI})
               alu_b = imm_zext;
            else
               alu_b = imm_sext;
            // Branches compare two registers
            if (op inside {OPC_BEQ, OPC_BNE})
               alu_b = rt;
            wr_dst = rt_num;
            wr_en  = (rt_num != 5'd0) && !(op inside {OPC_SW, OPC_BEQ, OPC_BNE});
         end
      end
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   ID/EX producer for the ALU: decodes the incoming instruction and holds
//   it in a 2-entry buffer (output register + skid register).
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     flush                kill buffered entries and the entry offered now
//     in_valid/in_ready    upstream handshake; in_instr, in_rs, in_rt payload
//     out_valid/out_ready  downstream handshake
//     alu_a, alu_b         ALU operands
//     alu_oper             ALU operation code
//     wr_dst, wr_en        register-file write target
//     illegal              unsupported instruction marker
//
// Handshake: an entry moves in on a cycle where in_valid & in_ready, and out
// on a cycle where out_valid & out_ready. in_ready depends only on the skid
// register (and rst), never on in_valid, so upstream may hold in_valid with
// stable payload until it is taken. Output fields never change while
// out_valid & ~out_ready. Entries leave in the order they arrived.

module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32  // only 32 is supported
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_oper,
   output logic [4:0]        wr_dst,
   output logic              wr_en,
   output logic              illegal
);

   issue_t dec;
   issue_t out_q;
   issue_t skid_q;
   logic   out_valid_q;
   logic   skid_valid;
   logic   accept;
   logic   load_out;

   alu_issue_decode u_decode (
      .instr    (in_instr),
      .rs       (in_rs),
      .rt       (in_rt),
      .alu_a    (dec.a),
      .alu_b    (dec.b),
      .alu_oper (dec.oper),
      .wr_dst   (dec.dst),
      .wr_en    (dec.wr_en),
      .illegal  (dec.illegal)
   );

   // The skid register only fills while the output is held, so a full skid
   // means both slots are busy.
   assign in_ready = ~skid_valid & ~rst;

   // An entry offered during flush is dropped even if in_ready is high.
   assign accept   = in_valid & in_ready & ~flush;
   assign load_out = ~out_valid_q | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (load_out) begin
         // Skid holds the older entry; when it is full in_ready is low, so
         // no new entry competes for the output register this cycle.
         if (skid_valid) begin
            out_q       <= skid_q;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_a     = out_q.a;
   assign alu_b     = out_q.b;
   assign alu_oper  = out_q.oper;
   assign wr_dst    = out_q.dst;
   assign wr_en     = out_q.wr_en;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Bench for alu_issue: directed scenarios plus randomized traffic, checked
//   against a table-driven instruction model and an in-order expected queue.

module tb_alu_issue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_oper;
   logic [4:0]  wr_dst;
   logic        wr_en;
   logic        illegal;

   alu_issue #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_oper  (alu_oper),
      .wr_dst    (wr_dst),
      .wr_en     (wr_en),
      .illegal   (illegal)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  oper;
      logic [4:0]  dst;
      logic        wr;
      logic        ill;
   } ent_t;

   localparam int ENT_W = $bits(ent_t);

   logic [ENT_W-1:0] exp_q[$];

   int vectors    = 0;
   int miscompares = 0;

   // Opcode tables keyed by funct (R-type) or primary opcode (I-type)
   logic [4:0] r_oper[int];
   logic [4:0] i_oper[int];
   bit         shamt_fn[int];
   bit         zext_op[int];
   bit         nowr_op[int];
   bit         rtb_op[int];

   task automatic init_tables();
      r_oper[32'h20] = 5'd2;  r_oper[32'h21] = 5'd10; r_oper[32'h22] = 5'd6;
      r_oper[32'h23] = 5'd14; r_oper[32'h24] = 5'd0;  r_oper[32'h25] = 5'd1;
      r_oper[32'h26] = 5'd9;  r_oper[32'h27] = 5'd8;  r_oper[32'h2A] = 5'd7;
      r_oper[32'h2B] = 5'd11; r_oper[32'h00] = 5'd3;  r_oper[32'h02] = 5'd4;
      r_oper[32'h03] = 5'd5;  r_oper[32'h04] = 5'd12; r_oper[32'h06] = 5'd13;
      r_oper[32'h07] = 5'd15;
      i_oper[32'h08] = 5'd2;  i_oper[32'h09] = 5'd16; i_oper[32'h0A] = 5'd19;
      i_oper[32'h0B] = 5'd20; i_oper[32'h0C] = 5'd0;  i_oper[32'h0D] = 5'd1;
      i_oper[32'h0E] = 5'd17; i_oper[32'h0F] = 5'd18; i_oper[32'h23] = 5'd10;
      i_oper[32'h2B] = 5'd10; i_oper[32'h04] = 5'd6;  i_oper[32'h05] = 5'd6;
      shamt_fn[32'h00] = 1; shamt_fn[32'h02] = 1; shamt_fn[32'h03] = 1;
      zext_op[32'h0C] = 1; zext_op[32'h0D] = 1; zext_op[32'h0E] = 1; zext_op[32'h0F] = 1;
      nowr_op[32'h2B] = 1; nowr_op[32'h04] = 1; nowr_op[32'h05] = 1;
      rtb_op[32'h04] = 1; rtb_op[32'h05] = 1;
   endtask

   function automatic ent_t ref_decode(input logic [31:0] instr, input logic [31:0] rs,
                                       input logic [31:0] rt);
      ent_t e;
      int op, funct, rt_n, rd_n, shamt, imm;
      op    = int'(instr[31:26]);
      rt_n  = int'(instr[20:16]);
      rd_n  = int'(instr[15:11]);
      shamt = int'(instr[10:6]);
      funct = int'(instr[5:0]);
      imm   = int'(instr[15:0]);
      e = '0;
      if (op == 0 && r_oper.exists(funct)) begin
         e.oper = r_oper[funct];
         e.a    = shamt_fn.exists(funct) ? 32'(shamt) : rs;
         e.b    = rt;
         e.dst  = 5'(rd_n);
         e.wr   = (rd_n != 0);
      end else if (op != 0 && i_oper.exists(op)) begin
         e.oper = i_oper[op];
         e.a    = rs;
         if (rtb_op.exists(op))       e.b = rt;
         else if (zext_op.exists(op)) e.b = 32'(imm);
         else                         e.b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
         e.dst  = 5'(rt_n);
         e.wr   = (rt_n != 0) && !nowr_op.exists(op);
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: predict transfers from the current inputs, advance the model
   // after the edge, then compare the DUT against it.
   task automatic cycle();
      bit   exp_rdy, fire_in, fire_out;
      ent_t e;
      exp_rdy  = !rst && (exp_q.size() < 2);
      fire_in  = in_valid && exp_rdy && !flush;
      fire_out = (exp_q.size() > 0) && out_ready;
      e = '0;
      if (fire_in) e = ref_decode(in_instr, in_rs, in_rt);
      @(posedge clk);
      #1;
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (fire_out) void'(exp_q.pop_front());
         if (fire_in)  exp_q.push_back(e);
      end
      check("in_ready", 32'(in_ready), 32'(!rst && (exp_q.size() < 2)));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         e = exp_q[0];
         check("oper", 32'(alu_oper), 32'(e.oper));
         check("wr_en", 32'(wr_en), 32'(e.wr));
         check("illegal", 32'(illegal), 32'(e.ill));
         if (!e.ill) begin
            check("alu_a", alu_a, e.a);
            check("alu_b", alu_b, e.b);
            check("wr_dst", 32'(wr_dst), 32'(e.dst));
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_rs     = rs;
      in_rt     = rt;
      out_ready = ordy;
      flush     = fl;
      cycle();
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops[14];
      logic [5:0] fns[17];
      logic [31:0] w;
      ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
              6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01};
      w = $urandom;
      if ($urandom_range(0, 9) == 0)
         w[31:26] = 6'($urandom_range(0, 63));
      else
         w[31:26] = ops[$urandom_range(0, 13)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
         w[5:0] = fns[$urandom_range(0, 16)];
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      return w;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      init_tables();
      rst = 1'b1;
      flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs = '0; in_rt = '0; out_ready = 1'b0;

      // Reset state
      drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
      idle(1'b1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_a", alu_a, 32'd0);
      check("rst_b", alu_b, 32'd0);
      check("rst_oper", 32'(alu_oper), 32'd0);
      check("rst_dst", 32'(wr_dst), 32'd0);
      check("rst_wr_illegal", {30'd0, wr_en, illegal}, 32'd0);
      rst = 1'b0;

      // Basic decode, one cycle latency
      drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);           // add $3,$1,$2
      check("add_oper", 32'(alu_oper), 32'b00010);
      check("add_ab", {alu_a[15:0], alu_b[15:0]}, {16'd5, 16'd7});
      check("add_dst_wr", {26'd0, wr_dst, wr_en}, {26'd0, 5'd3, 1'b1});
      drive(1'b1, 32'h00022103, 32'h1234, 32'h80000000, 1'b1, 1'b0); // sra $4,$2,4
      check("sra_a", alu_a, 32'd4);
      check("sra_b", alu_b, 32'h80000000);
      check("sra_oper", 32'(alu_oper), 32'b00101);
      drive(1'b1, 32'h2005FFFF, 32'h0, 32'h0, 1'b1, 1'b0);           // addi $5,$0,-1
      check("addi_b", alu_b, 32'hFFFFFFFF);
      drive(1'b1, 32'h3405FFFF, 32'h0, 32'h0, 1'b1, 1'b0);           // ori $5,$0,0xFFFF
      check("ori_b", alu_b, 32'h0000FFFF);
      check("ori_oper", 32'(alu_oper), 32'b00001);

      // Store/branch/illegal
      drive(1'b1, 32'hAC220004, 32'h10, 32'h20, 1'b1, 1'b0);         // sw
      check("sw_wr", 32'(wr_en), 32'd0);
      drive(1'b1, 32'h10220003, 32'h10, 32'h20, 1'b1, 1'b0);         // beq
      check("beq_wr", 32'(wr_en), 32'd0);
      check("beq_b", alu_b, 32'h20);
      drive(1'b1, 32'hFC000000, 32'h10, 32'h20, 1'b1, 1'b0);         // op 0x3F
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_oper_wr", {26'd0, alu_oper, wr_en}, 32'd0);
      idle(1'b1);

      // Back-to-back with stalled consumer, then release
      drive(1'b1, 32'h00221820, 32'd11, 32'd22, 1'b0, 1'b0);
      drive(1'b1, 32'h00221822, 32'd33, 32'd44, 1'b0, 1'b0);
      check("b2b_in_ready", 32'(in_ready), 32'd0);
      idle(1'b0);
      check("b2b_hold_a", alu_a, 32'd11);
      idle(1'b1);
      check("b2b_second_a", alu_a, 32'd33);
      idle(1'b1);
      check("b2b_drained", 32'(out_valid), 32'd0);

      // Flush with both slots full and an incoming entry
      drive(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
      drive(1'b1, 32'h00221820, 32'd3, 32'd4, 1'b0, 1'b0);
      drive(1'b1, 32'h00221820, 32'd5, 32'd6, 1'b0, 1'b1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      idle(1'b1);
      idle(1'b1);
      // Flush while empty and ready: offered entry is still dropped
      drive(1'b1, 32'h00221820, 32'd7, 32'd8, 1'b1, 1'b1);
      check("flush_drop", 32'(out_valid), 32'd0);

      // Reset mid-stream
      drive(1'b1, 32'h00221820, 32'd9, 32'd10, 1'b0, 1'b0);
      drive(1'b1, 32'h00221820, 32'd11, 32'd12, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 32'h00221820, 32'd13, 32'd14, 1'b1, 1'b0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd0);
      check("rst_mid_zero", alu_a | alu_b | 32'(alu_oper) | 32'(wr_dst) | 32'(wr_en)
            | 32'(out_valid), 32'd0);
      rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      end
      rst = 1'b0;
      repeat (4) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
